// File: rtl/cr_pkg.sv
// Shared constants and word types for the cognitive-radio transmit controller.
package cr_pkg;
    localparam int D_LEN_DEF = 32;
    localparam int NUM_BANDS = 3;

    typedef logic [D_LEN_DEF:0]   lic_word_t;
    typedef logic [2*D_LEN_DEF:0] unlic_word_t;
endpackage

// File: rtl/cr_band_slot.sv
// One spectrum band: selects licensed pass-through or packed secondary data, registered.
module cr_band_slot
    import cr_pkg::*;
#(
    parameter int D_LEN = D_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic [D_LEN:0]   l_in,
    input  logic [D_LEN:0]   u_lo,
    input  logic [D_LEN:0]   u_hi,
    output logic [D_LEN:0]   l_out,
    output logic [2*D_LEN:0] u_out
);

    // The high word loses its MSB so the packed word fits in 2*D_LEN+1 bits.
    function automatic logic [2*D_LEN:0] pack_unlic(input logic [D_LEN:0] lo,
                                                    input logic [D_LEN:0] hi);
        return {hi[D_LEN-1:0], lo};
    endfunction

    logic [D_LEN:0]   l_out_p1;
    logic [2*D_LEN:0] u_out_p1;

    // Stage p1: the idle path is forced to zero so only one output is live per band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_out_p1 <= '0;
            u_out_p1 <= '0;
        end else if (d) begin
            l_out_p1 <= l_in;
            u_out_p1 <= '0;
        end else begin
            l_out_p1 <= '0;
            u_out_p1 <= pack_unlic(u_lo, u_hi);
        end
    end

    assign l_out = l_out_p1;
    assign u_out = u_out_p1;

endmodule

// File: rtl/cr_controller_transmitter.sv
// Three-band transmit controller; each band is an independent cr_band_slot.
module cr_controller_transmitter
    import cr_pkg::*;
#(
    parameter int D_LEN = D_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [D_LEN:0]   l_in1,
    input  logic [D_LEN:0]   l_in2,
    input  logic [D_LEN:0]   l_in3,
    input  logic             d1,
    input  logic             d2,
    input  logic             d3,
    input  logic [D_LEN:0]   u_in1,
    input  logic [D_LEN:0]   u_in2,
    input  logic [D_LEN:0]   u_in3,
    input  logic [D_LEN:0]   u_in4,
    input  logic [D_LEN:0]   u_in5,
    input  logic [D_LEN:0]   u_in6,
    output logic [D_LEN:0]   l_out1,
    output logic [D_LEN:0]   l_out2,
    output logic [D_LEN:0]   l_out3,
    output logic [2*D_LEN:0] u_out1,
    output logic [2*D_LEN:0] u_out2,
    output logic [2*D_LEN:0] u_out3
);

    logic                   d_a     [NUM_BANDS];
    logic [D_LEN:0]         l_in_a  [NUM_BANDS];
    logic [D_LEN:0]         u_lo_a  [NUM_BANDS];
    logic [D_LEN:0]         u_hi_a  [NUM_BANDS];
    logic [D_LEN:0]         l_out_a [NUM_BANDS];
    logic [2*D_LEN:0]       u_out_a [NUM_BANDS];

    assign d_a[0] = d1;
    assign d_a[1] = d2;
    assign d_a[2] = d3;
    assign l_in_a[0] = l_in1;
    assign l_in_a[1] = l_in2;
    assign l_in_a[2] = l_in3;
    // Band k takes the odd unlicensed input as its low word and the even one as its high word.
    assign u_lo_a[0] = u_in1;
    assign u_hi_a[0] = u_in2;
    assign u_lo_a[1] = u_in3;
    assign u_hi_a[1] = u_in4;
    assign u_lo_a[2] = u_in5;
    assign u_hi_a[2] = u_in6;

    for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
        cr_band_slot #(.D_LEN(D_LEN)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d_a[k]),
            .l_in  (l_in_a[k]),
            .u_lo  (u_lo_a[k]),
            .u_hi  (u_hi_a[k]),
            .l_out (l_out_a[k]),
            .u_out (u_out_a[k])
        );
    end

    assign l_out1 = l_out_a[0];
    assign l_out2 = l_out_a[1];
    assign l_out3 = l_out_a[2];
    assign u_out1 = u_out_a[0];
    assign u_out2 = u_out_a[1];
    assign u_out3 = u_out_a[2];

endmodule

// File: tb/tb_cr_controller_transmitter.sv
// Randomized and directed bench for cr_controller_transmitter against an arithmetic band model.
module tb_cr_controller_transmitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  d = 3'b000;
    logic [32:0] l_in [3];
    logic [32:0] u_in [6];
    logic [32:0] l_out [3];
    logic [64:0] u_out [3];

    logic [32:0] exp_l [3];
    logic [64:0] exp_u [3];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    cr_controller_transmitter #(.D_LEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .l_in1  (l_in[0]),
        .l_in2  (l_in[1]),
        .l_in3  (l_in[2]),
        .d1     (d[0]),
        .d2     (d[1]),
        .d3     (d[2]),
        .u_in1  (u_in[0]),
        .u_in2  (u_in[1]),
        .u_in3  (u_in[2]),
        .u_in4  (u_in[3]),
        .u_in5  (u_in[4]),
        .u_in6  (u_in[5]),
        .l_out1 (l_out[0]),
        .l_out2 (l_out[1]),
        .l_out3 (l_out[2]),
        .u_out1 (u_out[0]),
        .u_out2 (u_out[1]),
        .u_out3 (u_out[2])
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Packed secondary word: even input modulo 2^32, shifted above the full 33-bit odd input.
    function automatic logic [64:0] model_pack(input logic [32:0] lo, input logic [32:0] hi);
        logic [64:0] h;
        h = 65'(hi % 33'h1_0000_0000);
        return h * (65'd1 << 33) + 65'(lo);
    endfunction

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_l%0d", tag, k + 1), 65'(l_out[k]), 65'(exp_l[k]));
            check($sformatf("%s_u%0d", tag, k + 1), u_out[k], exp_u[k]);
            check($sformatf("%s_mx%0d", tag, k + 1),
                  65'((l_out[k] != 0) && (u_out[k] != 0)), 65'd0);
        end
    endtask

    // Advance one edge: model the registered result from inputs present at the edge.
    task automatic step(input string tag);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                exp_l[k] = '0;
                exp_u[k] = '0;
            end else if (d[k]) begin
                exp_l[k] = l_in[k];
                exp_u[k] = '0;
            end else begin
                exp_l[k] = '0;
                exp_u[k] = model_pack(u_in[2*k], u_in[2*k+1]);
            end
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    function automatic logic [32:0] rnd33();
        return {1'($urandom_range(1, 0)), 32'($urandom())};
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) l_in[k] = rnd33() | 33'd1;
        for (int k = 0; k < 6; k++) u_in[k] = rnd33() | 33'd1;
        d = 3'b010;
        #2;
        for (int k = 0; k < 3; k++) begin
            exp_l[k] = '0;
            exp_u[k] = '0;
        end
        check_outputs("rst_imm");
        step("rst_hold");
        rst_n = 1'b1;

        d = 3'b111;
        l_in[0] = 33'h0_1234_5678;
        l_in[1] = 33'h1_0000_0001;
        l_in[2] = 33'h0_DEAD_BEEF;
        step("all_lic");
        check("all_lic_l2_const", 65'(l_out[1]), 65'h1_0000_0001);

        d = 3'b110;
        u_in[0] = 33'h1_8000_0001;
        u_in[1] = 33'h1_0000_00FF;
        step("b1_free");
        check("b1_pack_const", u_out[0], {32'h0000_00FF, 33'h1_8000_0001});

        d = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            u_in[2*k-2] = 33'(k);
            u_in[2*k-1] = 33'(16 * k);
        end
        step("all_free");
        check("all_free_u3_const", u_out[2], (65'd48 << 33) | 65'd3);

        d = 3'b101;
        for (int i = 0; i < 8; i++) begin
            d[1] = ~d[1];
            step($sformatf("tog%0d", i));
        end

        for (int i = 0; i < 200; i++) begin
            d = 3'($urandom());
            for (int k = 0; k < 3; k++) l_in[k] = rnd33();
            for (int k = 0; k < 6; k++) u_in[k] = rnd33();
            step("rnd");
        end

        d = 3'b110;
        u_in[0] = 33'h1_2345_6789;
        u_in[1] = 33'h0_ABCD_0123;
        step("pre_rst");
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_l[k] = '0;
            exp_u[k] = '0;
        end
        check_outputs("mid_rst");
        step("mid_rst_hold");
        rst_n = 1'b1;
        step("post_rst");
        d = 3'b001;
        step("post_rst2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
